i2c_init_sequencer: RTL and testbench

Upstream driver for the I2C byte-write master. Walks a fixed table of (register, data) pairs and presents each pair on the master's slave_address/slave_register/slave_data inputs. Runs the active-low enable_send handshake for every entry and checks the returned i2c_status ack bits. Reports done or error with the failing entry index, so a peripheral can be brought up after reset with a single start pulse.

---
 rtl/i2c_seq_pkg.sv | 56 +++++
 rtl/i2c_init_sequencer_if.sv | 31 +++
 rtl/i2c_seq_rom.sv | 20 ++
 rtl/i2c_init_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types and constants for the I2C init sequencer.
// Holds the FSM state enum, ack mask, error codes, table entry type and the
// default peripheral init table.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ASSERT,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Address, register and data ack flags reported by the byte-write master
  localparam logic [7:0] ACK_MASK = 8'h2A;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_NACK       = 2'd1;
  localparam logic [1:0] ERR_ASSERT_TO  = 2'd2;
  localparam logic [1:0] ERR_RELEASE_TO = 2'd3;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  localparam int MAX_TABLE = 16;

  // Default bring-up table; only the first NUM_ENTRIES rows are walked
  localparam entry_t INIT_TABLE [MAX_TABLE] = '{
    '{8'h00, 8'hAE},
    '{8'hD5, 8'h80},
    '{8'hA8, 8'h3F},
    '{8'h8D, 8'h14},
    '{8'h20, 8'h00},
    '{8'hA1, 8'h01},
    '{8'hC8, 8'h00},
    '{8'h81, 8'hCF},
    '{8'hD9, 8'hF1},
    '{8'hDB, 8'h40},
    '{8'hA4, 8'h00},
    '{8'hA6, 8'h00},
    '{8'h2E, 8'h00},
    '{8'hAF, 8'h00},
    '{8'h21, 8'h00},
    '{8'h22, 8'h00}
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// i2c_init_sequencer_if: bus between the init sequencer and the I2C
// byte-write master. The master modport is the sequencer side (it masters
// the handshake); the slave modport is the byte-write engine side.
interface i2c_init_sequencer_if;

  logic       i2c_busy;
  logic [7:0] i2c_status;
  logic [7:0] slave_address;
  logic [7:0] slave_register;
  logic [7:0] slave_data;
  logic       enable_send;

  modport master (
    input  i2c_busy,
    input  i2c_status,
    output slave_address,
    output slave_register,
    output slave_data,
    output enable_send
  );

  modport slave (
    output i2c_busy,
    output i2c_status,
    input  slave_address,
    input  slave_register,
    input  slave_data,
    input  enable_send
  );

endinterface

// File: rtl/i2c_seq_rom.sv
// i2c_seq_rom: combinational lookup of one init table entry by index.
// Indices at or beyond NUM_ENTRIES return an all-zero entry.
module i2c_seq_rom
  import i2c_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic [3:0] idx,
  output entry_t     entry
);

  // Table read with out-of-range guard
  always_comb begin
    entry = '0;
    if (int'(idx) < NUM_ENTRIES) begin
      entry = INIT_TABLE[idx];
    end
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks the init table, running the active-low
// enable_send handshake with the I2C byte-write master for every entry and
// checking the returned ack flags. Reports done, or error with entry/code.
// Optional feature: define I2C_SEQ_RETRY_EN to retry a NACKed entry up to
// MAX_RETRIES extra times before giving up.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int         NUM_ENTRIES    = 4,
  parameter logic [7:0] SLAVE_ADDR     = 8'h3C,
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter int         GAP_CYCLES     = 1024,
  parameter int         MAX_RETRIES    = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  i2c_init_sequencer_if.master        bus,
  output logic                        done,
  output logic                        error,
  output logic [3:0]                  err_index,
  output logic [1:0]                  err_code,
  output logic                        led
);

  localparam int TIMER_W = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         LAST_IDX  = 4'(NUM_ENTRIES - 1);

  state_t               state;
  state_t               next_state;
  logic [3:0]           idx;
  logic [3:0]           next_idx;
  logic [1:0]           fail_code;
  logic [TIMER_W-1:0]   timer;
  logic                 busy_meta;
  logic                 busy_sync;
  logic                 ack_ok;
  entry_t               rom_entry;
  logic [7:0]           reg_q;
  logic [7:0]           data_q;

  assign ack_ok = ((bus.i2c_status & ACK_MASK) == ACK_MASK);

  assign bus.slave_address  = SLAVE_ADDR;
  assign bus.slave_register = reg_q;
  assign bus.slave_data     = data_q;

  // The entry to present is looked up for the index we are about to hold
  i2c_seq_rom #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_rom (
    .idx   (next_idx),
    .entry (rom_entry)
  );

`ifdef I2C_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_pending;
  logic               retry_ok;

  assign retry_ok = (int'(retry_cnt) < MAX_RETRIES);

  // Retry bookkeeping: count NACKs per entry, remember whether RELEASE is a retry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retry_cnt     <= '0;
      retry_pending <= 1'b0;
    end else if (state == ST_CHECK) begin
      retry_pending <= !ack_ok;
      if (!ack_ok && retry_ok) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end else if ((state inside {ST_IDLE, ST_DONE, ST_ERROR}) || (next_idx != idx)) begin
      retry_cnt <= '0;
    end
  end
`endif

  // Two-flop synchronizer for the asynchronous busy flag (idle level is 1)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_meta <= 1'b1;
      busy_sync <= 1'b1;
    end else begin
      busy_meta <= bus.i2c_busy;
      busy_sync <= busy_meta;
    end
  end

  // State and entry index registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // Next-state logic, including timeout and NACK decisions
  always_comb begin
    next_state = state;
    next_idx   = idx;
    fail_code  = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_LOAD;
          next_idx   = '0;
        end
      end
      ST_LOAD: begin
        next_state = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!busy_sync) begin
          next_state = ST_WAIT_DONE;
        end else if (timer >= TIMEOUT_T) begin
          next_state = ST_ERROR;
          fail_code  = ERR_ASSERT_TO;
        end
      end
      ST_WAIT_DONE: begin
        if (busy_sync) begin
          next_state = ST_CHECK;
        end else if (timer >= TIMEOUT_T) begin
          next_state = ST_ERROR;
          fail_code  = ERR_RELEASE_TO;
        end
      end
      ST_CHECK: begin
        if (ack_ok) begin
          next_state = ST_RELEASE;
        end
`ifdef I2C_SEQ_RETRY_EN
        else if (retry_ok) begin
          next_state = ST_RELEASE;
        end
`endif
        else begin
          next_state = ST_ERROR;
          fail_code  = ERR_NACK;
        end
      end
      ST_RELEASE: begin
        if (timer >= GAP_LAST) begin
`ifdef I2C_SEQ_RETRY_EN
          if (retry_pending) begin
            next_state = ST_LOAD;
          end else
`endif
          if (idx == LAST_IDX) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_LOAD;
            next_idx   = idx + 4'd1;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          next_state = ST_LOAD;
          next_idx   = '0;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_idx   = '0;
      end
    endcase
  end

  // Handshake output: request is held low only while a transfer is in flight
  always_comb begin
    bus.enable_send = 1'b1;
    if ((state == ST_ASSERT) || (state == ST_WAIT_DONE)) begin
      bus.enable_send = 1'b0;
    end
  end

  // Phase timer: cleared on every state change, saturates at all ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (next_state != state) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + 1'b1;
    end
  end

  // Entry fields latched on entry to LOAD so they stay stable until the next LOAD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_q  <= '0;
      data_q <= '0;
    end else if ((next_state == ST_LOAD) && (state != ST_LOAD)) begin
      reg_q  <= rom_entry.reg_addr;
      data_q <= rom_entry.data;
    end
  end

  // Registered status flags, valid on the first clock of the new state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done      <= 1'b0;
      error     <= 1'b0;
      led       <= 1'b0;
      err_index <= '0;
      err_code  <= ERR_NONE;
    end else begin
      done  <= (next_state == ST_DONE);
      error <= (next_state == ST_ERROR);
      led   <= !(next_state inside {ST_IDLE, ST_DONE, ST_ERROR});
      if ((next_state == ST_ERROR) && (state != ST_ERROR)) begin
        err_index <= idx;
        err_code  <= fail_code;
      end else if ((next_state == ST_LOAD) &&
                   (state inside {ST_IDLE, ST_DONE, ST_ERROR})) begin
        err_index <= '0;
        err_code  <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: directed and randomized checks of the init sequencer
// against a transfer-level reference model and a bus-functional I2C master.
module tb_i2c_init_sequencer;

  localparam int         NUM      = 4;
  localparam logic [7:0] ADDR     = 8'h3C;
  localparam int         TIMEOUT  = 800;
  localparam int         GAP      = 32;
  localparam int         RETRIES  = 2;

  logic       clock;
  logic       reset;
  logic       start;
  logic       done;
  logic       error;
  logic [3:0] err_index;
  logic [1:0] err_code;
  logic       led;

  i2c_init_sequencer_if bus ();

  i2c_init_sequencer #(
    .NUM_ENTRIES    (NUM),
    .SLAVE_ADDR     (ADDR),
    .TIMEOUT_CYCLES (TIMEOUT),
    .GAP_CYCLES     (GAP),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .err_code  (err_code),
    .led       (led)
  );

  // Expected table contents {register, data}
  logic [15:0] tbl [NUM] = '{16'h00AE, 16'hD580, 16'hA83F, 16'h8D14};

  int n_cmp  = 0;
  int n_fail = 0;

  // Scenario and reference model state
  int unsigned nack_cnt [NUM];
  logic [7:0]  nack_val;
  int          exp_seq [$];
  logic [7:0]  status_q [$];
  bit          exp_err;
  int          exp_eidx;

  // Bus-functional master state
  logic [23:0] got [$];
  int          gaps [$];
  bit          gap_armed;
  int          high_cnt;
  bit          bfm_no_busy;
  int          bfm_phase;
  int          bfm_cnt;
  int          bfm_hold;
  logic        en_prev;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net in case a bounded wait is mis-sized
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Bus-functional I2C byte-write master driven on the falling edge
  initial begin
    bus.i2c_busy   = 1'b1;
    bus.i2c_status = 8'h00;
    bfm_phase      = 0;
    bfm_cnt        = 0;
    bfm_hold       = 0;
    en_prev        = 1'b1;
    high_cnt       = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bfm_phase    = 0;
        bus.i2c_busy = 1'b1;
        en_prev      = 1'b1;
      end else begin
        case (bfm_phase)
          0: begin
            if (bus.enable_send) high_cnt++;
            if (en_prev && !bus.enable_send) begin
              got.push_back({bus.slave_address, bus.slave_register, bus.slave_data});
              if (gap_armed) gaps.push_back(high_cnt);
              gap_armed = 1'b1;
              high_cnt  = 0;
              if (!bfm_no_busy) begin
                bfm_phase = 1;
                bfm_cnt   = 0;
              end
            end
          end
          1: begin
            bfm_cnt++;
            if (bfm_cnt == 3) begin
              bus.i2c_busy = 1'b0;
              bfm_cnt      = 0;
              bfm_hold     = $urandom_range(20, 600);
              bfm_phase    = 2;
            end
          end
          default: begin
            bfm_cnt++;
            if (bfm_cnt == bfm_hold) begin
              bus.i2c_status = (status_q.size() > 0) ? status_q.pop_front() : 8'h2A;
              bus.i2c_busy   = 1'b1;
              bfm_phase      = 0;
            end
          end
        endcase
        en_prev = bus.enable_send;
      end
    end
  end

  // Transfer-level model: which entries get sent, with which status, and the final outcome
  function automatic void build_model();
    int allowed;
`ifdef I2C_SEQ_RETRY_EN
    allowed = RETRIES + 1;
`else
    allowed = 1;
`endif
    exp_seq.delete();
    status_q.delete();
    exp_err  = 1'b0;
    exp_eidx = 0;
    for (int i = 0; i < NUM; i++) begin
      int tries;
      tries = (int'(nack_cnt[i]) >= allowed) ? allowed : int'(nack_cnt[i]) + 1;
      for (int a = 0; a < tries; a++) begin
        exp_seq.push_back(i);
        status_q.push_back((a < int'(nack_cnt[i])) ? nack_val : 8'h2A);
      end
      if (int'(nack_cnt[i]) >= allowed) begin
        exp_err  = 1'b1;
        exp_eidx = i;
        break;
      end
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start and check the two-clock path to enable_send falling
  task automatic apply_stimulus(input string name);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_output({name, "_load_en"}, bus.enable_send, 1);
    check_output({name, "_load_led"}, led, 1);
    check_output({name, "_load_done"}, done, 0);
    check_output({name, "_load_error"}, error, 0);
    check_output({name, "_load_code"}, err_code, 0);
    check_output({name, "_load_index"}, err_index, 0);
    @(negedge clock);
    check_output({name, "_assert_en"}, bus.enable_send, 0);
  endtask

  task automatic check_results(input string name);
    int min_gap;
    check_output({name, "_done"}, done, !exp_err);
    check_output({name, "_error"}, error, exp_err);
    check_output({name, "_led"}, led, 0);
    check_output({name, "_en_idle"}, bus.enable_send, 1);
    check_output({name, "_code"}, err_code, exp_err ? 1 : 0);
    check_output({name, "_index"}, err_index, exp_err ? exp_eidx : 0);
    check_output({name, "_count"}, got.size(), exp_seq.size());
    for (int i = 0; i < got.size() && i < exp_seq.size(); i++) begin
      check_output($sformatf("%s_xfer%0d", name, i), got[i], {ADDR, tbl[exp_seq[i]]});
    end
    if (exp_seq.size() > 1) begin
      check_output({name, "_gap_count"}, gaps.size(), exp_seq.size() - 1);
      min_gap = 1 << 30;
      foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
      check_output({name, "_gap_min"}, (min_gap >= GAP), 1);
    end
  endtask

  task automatic run_sequence(input string name, input bit poke_release);
    build_model();
    got.delete();
    gaps.delete();
    gap_armed = 1'b0;
    high_cnt  = 0;
    apply_stimulus(name);
    if (poke_release) begin
      for (int c = 0; c < 5000; c++) begin
        @(negedge clock);
        if (bus.enable_send) break;
      end
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_output({name, "_poke_en"}, bus.enable_send, 1);
      check_output({name, "_poke_led"}, led, 1);
    end
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock);
      if (done || error) break;
    end
    check_output({name, "_finished"}, (done || error), 1);
    repeat (10) @(negedge clock);
    check_results(name);
  endtask

  initial begin
    int low_cnt;
    reset       = 1'b0;
    start       = 1'b0;
    bfm_no_busy = 1'b0;
    gap_armed   = 1'b0;
    nack_val    = 8'h26;
    foreach (nack_cnt[i]) nack_cnt[i] = 0;

    repeat (3) @(negedge clock);
    check_output("rst_en", bus.enable_send, 1);
    check_output("rst_addr", bus.slave_address, ADDR);
    check_output("rst_reg", bus.slave_register, 0);
    check_output("rst_data", bus.slave_data, 0);
    check_output("rst_done", done, 0);
    check_output("rst_error", error, 0);
    check_output("rst_index", err_index, 0);
    check_output("rst_code", err_code, 0);
    check_output("rst_led", led, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] all-ack run with start pulse during RELEASE");
    run_sequence("ack", 1'b1);

    $display("[TB] register NACK on entry 2");
    foreach (nack_cnt[i]) nack_cnt[i] = 0;
    nack_cnt[2] = 1;
    nack_val    = 8'h26;
    run_sequence("nack2", 1'b0);

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random scenario %0d", r);
      foreach (nack_cnt[i]) nack_cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      nack_val = 8'($urandom) & ~(8'h02 << (2 * $urandom_range(0, 2)));
      run_sequence($sformatf("rand%0d", r), 1'b0);
    end

    $display("[TB] busy never asserted: ASSERT timeout, start on expiry cycle ignored");
    foreach (nack_cnt[i]) nack_cnt[i] = 0;
    build_model();
    bfm_no_busy = 1'b1;
    apply_stimulus("to");
    low_cnt = 1;
    for (int c = 0; c < TIMEOUT + 50; c++) begin
      @(negedge clock);
      if (start) start = 1'b0;
      if (error) break;
      if (!bus.enable_send) begin
        low_cnt++;
        if (low_cnt == TIMEOUT + 1) start = 1'b1;
      end
    end
    start = 1'b0;
    check_output("to_low_cycles", low_cnt, TIMEOUT + 1);
    check_output("to_error", error, 1);
    check_output("to_code", err_code, 2);
    check_output("to_index", err_index, 0);
    check_output("to_done", done, 0);
    repeat (5) @(negedge clock);
    check_output("to_hold_error", error, 1);
    check_output("to_hold_en", bus.enable_send, 1);
    check_output("to_hold_led", led, 0);
    bfm_no_busy = 1'b0;

    $display("[TB] reset during WAIT_DONE of entry 1");
    build_model();
    got.delete();
    gaps.delete();
    gap_armed = 1'b0;
    apply_stimulus("rst_mid");
    for (int c = 0; c < 5000; c++) begin
      @(negedge clock);
      if (got.size() >= 2 && bfm_phase == 2 && bfm_cnt >= 8) break;
    end
    check_output("rst_mid_low", bus.enable_send, 0);
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_mid_en", bus.enable_send, 1);
    check_output("rst_mid_reg", bus.slave_register, 0);
    check_output("rst_mid_data", bus.slave_data, 0);
    check_output("rst_mid_addr", bus.slave_address, ADDR);
    check_output("rst_mid_led", led, 0);
    check_output("rst_mid_done", done, 0);
    check_output("rst_mid_error", error, 0);
    check_output("rst_mid_code", err_code, 0);
    check_output("rst_mid_index", err_index, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    run_sequence("after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
